// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the PC / EPC unit.
// Holds the exception sequencer states, cause codes and the address width.
package pc_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2
    } state_t;

    localparam logic [1:0] EXC_OPCODE = 2'd0;
    localparam logic [1:0] EXC_OVF    = 2'd1;
    localparam logic [1:0] EXC_DIV0   = 2'd2;
    localparam logic [1:0] EXC_ALIGN  = 2'd3;

endpackage

// File: rtl/pc_epc_unit_if.sv
// Bundle between the multicycle control/datapath and the PC / EPC unit.
// master: control side (drives pc_next, write enables, exc_req/code);
// slave: the PC unit (drives pc_out, epc_out, cause_out, exc_busy).
interface pc_epc_unit_if;
    import pc_unit_pkg::*;

    logic [XLEN-1:0] pc_next;
    logic            pc_write;
    logic            pc_write_cond;
    logic            branch_ne;
    logic            alu_zero;
    logic            exc_req;
    logic [1:0]      exc_code;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] epc_out;
    logic [1:0]      cause_out;
    logic            exc_busy;

    modport master (
        output pc_next, pc_write, pc_write_cond, branch_ne,
        output alu_zero, exc_req, exc_code,
        input  pc_out, epc_out, cause_out, exc_busy
    );

    modport slave (
        input  pc_next, pc_write, pc_write_cond, branch_ne,
        input  alu_zero, exc_req, exc_code,
        output pc_out, epc_out, cause_out, exc_busy
    );

endinterface

// File: rtl/pc_exc_fsm.sv
// Exception sequencer IDLE -> SAVE -> VECTOR with cause latch and busy flag.
// Ports: clk, reset_n, pc_we_i, align_fault_i, exc_req_i, exc_code_i in;
// pc_load_o, epc_load_o, vec_load_o, cause_o, busy_o out.
module pc_exc_fsm
    import pc_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pc_we_i,
    input  logic       align_fault_i,
    input  logic       exc_req_i,
    input  logic [1:0] exc_code_i,
    output logic       pc_load_o,
    output logic       epc_load_o,
    output logic       vec_load_o,
    output logic [1:0] cause_o,
    output logic       busy_o
);

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [1:0] cause_q, cause_d;
    logic       busy_q, busy_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            code_q  <= 2'd0;
            cause_q <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cause_q <= cause_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        cause_d    = cause_q;
        busy_d     = busy_q;
        pc_load_o  = 1'b0;
        epc_load_o = 1'b0;
        vec_load_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                // External request beats both alignment fault and write.
                if (exc_req_i) begin
                    state_d = SAVE;
                    code_d  = exc_code_i;
                    busy_d  = 1'b1;
                end else if (align_fault_i) begin
                    state_d = SAVE;
                    code_d  = EXC_ALIGN;
                    busy_d  = 1'b1;
                end else begin
                    pc_load_o = pc_we_i;
                end
            end
            SAVE: begin
                epc_load_o = 1'b1;
                cause_d    = code_q;
                state_d    = VECTOR;
            end
            VECTOR: begin
                vec_load_o = 1'b1;
                state_d    = IDLE;
                busy_d     = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign cause_o = cause_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/pc_epc_unit.sv
// Architectural PC register with EPC / cause capture and exception redirect.
// Ports: clk, reset_n, bus (pc_epc_unit_if.slave). Optional macro
// PC_ALIGN_CHECK_EN turns misaligned PC writes into cause-3 exceptions.
module pc_epc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0100,
    parameter logic [XLEN-1:0] EPC_OFFSET = 32'd4
) (
    input  logic          clk,
    input  logic          reset_n,
    pc_epc_unit_if.slave  bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            pc_we;
    logic            align_fault;
    logic            pc_load;
    logic            epc_load;
    logic            vec_load;
    logic [1:0]      cause;

    assign pc_we = bus.pc_write |
                   (bus.pc_write_cond & (bus.alu_zero ^ bus.branch_ne));

`ifdef PC_ALIGN_CHECK_EN
    assign align_fault = pc_we & (|bus.pc_next[1:0]);
`else
    assign align_fault = 1'b0;
`endif

    pc_exc_fsm u_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_we_i      (pc_we),
        .align_fault_i(align_fault),
        .exc_req_i    (bus.exc_req),
        .exc_code_i   (bus.exc_code),
        .pc_load_o    (pc_load),
        .epc_load_o   (epc_load),
        .vec_load_o   (vec_load),
        .cause_o      (cause),
        .busy_o       (bus.exc_busy)
    );

    always_comb begin
        pc_d = pc_q;
        if (vec_load) begin
            pc_d = EXC_VECTOR + {{(XLEN-4){1'b0}}, cause, 2'b00};
        end else if (pc_load) begin
            pc_d = bus.pc_next;
        end
    end

    // PC was already advanced at fetch, so back off to the faulting insn.
    assign epc_d = epc_load ? (pc_q - EPC_OFFSET) : epc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_PC;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.epc_out   = epc_q;
    assign bus.cause_out = cause;

endmodule

// File: tb/tb_pc_epc_unit.sv
// Self-checking bench for pc_epc_unit: directed literals plus random run
// against a queue-based reference model of the exception sequence.
module tb_pc_epc_unit;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   check_en = 1'b0;

    always #5 clk = ~clk;

    pc_epc_unit_if bus ();

    pc_epc_unit dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    bit          m_busy;
    int          act_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_epc   = 32'h0;
        m_cause = 2'd0;
        m_busy  = 1'b0;
        act_q.delete();
    endtask

    // Pending actions: 0..3 = save EPC with that cause, 4 = jump to vector.
    task automatic model_step();
        int  a;
        bit  we, fault;
        if (act_q.size() > 0) begin
            a = act_q.pop_front();
            if (a < 4) begin
                m_epc   = m_pc - 32'd4;
                m_cause = 2'(a);
            end else begin
                m_pc = 32'h100 + 32'(m_cause) * 4;
            end
        end else begin
            we = bus.pc_write ||
                 (bus.pc_write_cond && (bus.alu_zero != bus.branch_ne));
            fault = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fault = we && (bus.pc_next[1:0] != 2'b00);
`endif
            if (bus.exc_req) begin
                act_q.push_back(int'(bus.exc_code));
                act_q.push_back(4);
            end else if (fault) begin
                act_q.push_back(3);
                act_q.push_back(4);
            end else if (we) begin
                m_pc = bus.pc_next;
            end
        end
        m_busy = (act_q.size() != 0);
    endtask

    task automatic drive(bit w, bit c, bit ne, bit z, bit req,
                         logic [1:0] code, logic [31:0] nxt);
        bus.pc_write      = w;
        bus.pc_write_cond = c;
        bus.branch_ne     = ne;
        bus.alu_zero      = z;
        bus.exc_req       = req;
        bus.exc_code      = code;
        bus.pc_next       = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en && reset_n) begin
            chk("pc_model",    bus.pc_out,          m_pc);
            chk("epc_model",   bus.epc_out,         m_epc);
            chk("cause_model", 32'(bus.cause_out),  32'(m_cause));
            chk("busy_model",  32'(bus.exc_busy),   32'(m_busy));
        end
    end

    initial begin
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 2'd0, 32'h0);
        model_reset();
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_pc",    bus.pc_out,         32'h0);
        chk("rst_epc",   bus.epc_out,        32'h0);
        chk("rst_cause", 32'(bus.cause_out), 32'h0);
        chk("rst_busy",  32'(bus.exc_busy),  32'h0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        check_en = 1'b1;

        drive(1, 0, 0, 0, 0, 2'd0, 32'h4);      step();
        chk("wr_pc", bus.pc_out, 32'h4);
        drive(0, 1, 0, 0, 0, 2'd0, 32'h40);     step();
        chk("beq_nt", bus.pc_out, 32'h4);
        drive(0, 1, 0, 1, 0, 2'd0, 32'h40);     step();
        chk("beq_t", bus.pc_out, 32'h40);
        drive(0, 1, 1, 0, 0, 2'd0, 32'h80);     step();
        chk("bne_t", bus.pc_out, 32'h80);
        drive(0, 1, 1, 1, 0, 2'd0, 32'h90);     step();
        chk("bne_nt", bus.pc_out, 32'h80);

        drive(1, 0, 0, 0, 0, 2'd0, 32'h24);     step();
        drive(1, 0, 0, 0, 1, 2'd1, 32'h50);     step();
        chk("exc_nowr", bus.pc_out, 32'h24);
        chk("exc_busy1", 32'(bus.exc_busy), 32'h1);
        drive(0, 0, 0, 0, 0, 2'd0, 32'h0);      step();
        chk("exc_epc", bus.epc_out, 32'h20);
        chk("exc_cause", 32'(bus.cause_out), 32'h1);
        chk("exc_busy2", 32'(bus.exc_busy), 32'h1);
        step();
        chk("exc_vec", bus.pc_out, 32'h104);
        chk("exc_busy3", 32'(bus.exc_busy), 32'h0);

        drive(1, 0, 0, 0, 0, 2'd0, 32'h0);      step();
        drive(0, 0, 0, 0, 1, 2'd2, 32'h0);      step();
        drive(1, 0, 0, 0, 1, 2'd0, 32'h30);     step();
        chk("wrap_epc", bus.epc_out, 32'hFFFF_FFFC);
        chk("busy_ign", 32'(bus.cause_out), 32'h2);
        step();
        chk("div0_vec", bus.pc_out, 32'h108);
        step();
        chk("reenter", 32'(bus.exc_busy), 32'h1);
        chk("reenter_pc", bus.pc_out, 32'h108);
        drive(0, 0, 0, 0, 0, 2'd0, 32'h0);      step();
        chk("re_epc", bus.epc_out, 32'h104);
        step();
        chk("re_vec", bus.pc_out, 32'h100);

        drive(1, 0, 0, 0, 0, 2'd0, 32'h42);     step();
        drive(0, 0, 0, 0, 0, 2'd0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("al_nowr", bus.pc_out, 32'h100);
        step();
        chk("al_cause", 32'(bus.cause_out), 32'h3);
        step();
        chk("al_vec", bus.pc_out, 32'h10C);
`else
        chk("al_off", bus.pc_out, 32'h42);
`endif

        drive(0, 0, 0, 0, 1, 2'd1, 32'h0);      step();
        drive(0, 0, 0, 0, 0, 2'd0, 32'h0);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("abort_busy", 32'(bus.exc_busy), 32'h0);
        chk("abort_pc",   bus.pc_out,        32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] nxt;
            nxt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) nxt[1:0] = 2'($urandom);
            drive(1'($urandom_range(0, 3) == 0),
                  1'($urandom),
                  1'($urandom),
                  1'($urandom),
                  1'($urandom_range(0, 9) == 0),
                  2'($urandom),
                  nxt);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                chk("rnd_rst_pc", bus.pc_out, 32'h0);
                #1;
                reset_n = 1'b1;
            end
            step();
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_epc_unit.md
Name: pc_epc_unit

Overview:
- Architectural PC register plus exception capture (EPC, cause) for the multicycle datapath.
- Consumes the 32-bit output of the PC-source selector (ALU result / ALUOut / jump target / EPC) as pc_next.
- Decides when PC is written: unconditional write, conditional branch write, or exception redirect.
- Drives epc_out back to the selector's EPC input, and pc_out to memory address and ALU operand muxes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h0000_0100, exception handler base address.
- EPC_OFFSET, 4, amount subtracted from PC when saving EPC (PC already incremented at fetch).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- pc_next  in  32  candidate next PC from PC-source selector
- pc_write  in  1  unconditional PC write (fetch, jump)
- pc_write_cond  in  1  conditional PC write (branch)
- branch_ne  in  1  0 = beq (write when alu_zero), 1 = bne (write when !alu_zero)
- alu_zero  in  1  ALU zero flag
- exc_req  in  1  exception request, level, sampled each cycle
- exc_code  in  2  0 = invalid opcode, 1 = overflow, 2 = divide-by-zero, 3 = reserved
- pc_out  out  32  current PC
- epc_out  out  32  saved exception PC
- cause_out  out  2  saved exception code
- exc_busy  out  1  high while the exception sequence is running

Behaviour:
- Reset (async, reset_n = 0): pc_out = RESET_PC, epc_out = 0, cause_out = 0, exc_busy = 0, FSM = IDLE. Release takes effect at the next clk edge.
- Write enable in IDLE: pc_we = pc_write | (pc_write_cond & (alu_zero ^ branch_ne)).
- IDLE, exc_req = 0:
  - If pc_we: pc_out <= pc_next on the next edge (1-cycle latency).
  - Otherwise PC holds.
- IDLE, exc_req = 1:
  - Go to SAVE. PC is NOT written that cycle, even if pc_we = 1 (exception wins over a simultaneous write).
- SAVE (1 cycle):
  - epc_out <= pc_out - EPC_OFFSET, modulo 2^32 (wraps; 0 saves 32'hFFFF_FFFC).
  - cause_out <= exc_code latched at IDLE -> SAVE entry.
  - exc_busy = 1. Go to VECTOR.
- VECTOR (1 cycle):
  - pc_out <= EXC_VECTOR + {28'b0, cause, 2'b00}.
  - exc_busy = 1. Go to IDLE.
- exc_busy is a registered Moore output: high in SAVE and VECTOR only.
- While busy, pc_write, pc_write_cond and exc_req are ignored; a request still asserted on return to IDLE is serviced again.
- Total exception latency: exc_req sampled at edge N, EPC valid after edge N+1, PC = vector after edge N+2.
- Returning from an exception is a normal pc_write with pc_next = EPC. No special state.
- epc_out and cause_out change only in SAVE or on reset.
- Reset asserted mid-sequence aborts the sequence immediately; all outputs return to reset values.

Optional Feature:
- PC_ALIGN_CHECK_EN defined:
  - In IDLE, a pc_we with pc_next[1:0] != 0 does not write PC. It is treated as exc_req with code 3.
  - An external exc_req in the same cycle takes priority with its own code.
- Not defined: pc_next is written unchecked, and code 3 is only reachable via exc_code.

Decomposition:
- Package pc_unit_pkg holds:
  - state enum {IDLE, SAVE, VECTOR}
  - exception code constants EXC_OPCODE, EXC_OVF, EXC_DIV0, EXC_ALIGN
  - EPC/vector width constant, 32
- One natural sub-module: pc_exc_fsm. It contains the IDLE/SAVE/VECTOR sequencer and the exc_busy and cause latch, and drives PC/EPC load selects to the top-level registers.

Test Plan:
- Reset with reset_n = 0 mid-clock -> pc_out = 0, epc_out = 0, cause_out = 0, exc_busy = 0 immediately, without waiting for an edge.
- pc_write = 1, pc_next = 32'h4 -> pc_out = 32'h4 after 1 edge. Then pc_write_cond = 1, branch_ne = 0, alu_zero = 0 -> PC holds; then alu_zero = 1, pc_next = 32'h40 -> pc_out = 32'h40.
- bne case: pc_write_cond = 1, branch_ne = 1, alu_zero = 0, pc_next = 32'h80 -> pc_out = 32'h80; with alu_zero = 1 -> PC holds.
- pc_out = 32'h24, exc_req = 1, code = 1, pc_write = 1 in the same cycle -> PC not written; after edge+1 epc_out = 32'h20, cause_out = 1; after edge+2 pc_out = 32'h104; exc_busy high exactly 2 cycles.
- pc_out = 0, exc_req = 1, code = 2 -> epc_out = 32'hFFFF_FFFC, pc_out = 32'h108. A new exc_req during busy is ignored; exc_req held into IDLE re-enters SAVE.
- With PC_ALIGN_CHECK_EN: pc_write = 1, pc_next = 32'h42 -> PC not written, cause_out = 3, pc_out = 32'h10C. Without the macro: pc_out = 32'h42.
